// File: rtl/hcp_rx_port_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the HCP receive-port arbiter.
package hcp_rx_port_arbiter_pkg;

    localparam int DATA_W = 9;
    localparam int TS_W   = 19;
    localparam int PORT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XFER  = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_e;

    // Round-robin successor of a port index, wrapping at the last port.
    function automatic logic [PORT_W-1:0] next_port(input logic [PORT_W-1:0] idx,
                                                    input int num_ports);
        logic [PORT_W-1:0] last_idx;
        last_idx = PORT_W'(num_ports - 1);
        if (idx >= last_idx) begin
            next_port = {PORT_W{1'b0}};
        end else begin
            next_port = idx + 3'd1;
        end
    endfunction

endpackage

// File: rtl/hcp_rx_port_arbiter_rr_pick.sv
// Rotating-priority encoder: the first requester at or after ptr wins.
module hcp_rx_port_arbiter_rr_pick
    import hcp_rx_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    ptr,
    output logic [NUM_PORTS-1:0] grant_onehot,
    output logic [PORT_W-1:0]    grant_idx,
    output logic                 valid
);

    // Scan from farthest to nearest offset so the nearest requester overwrites last.
    always_comb begin
        grant_onehot = {NUM_PORTS{1'b0}};
        grant_idx    = {PORT_W{1'b0}};
        valid        = |req;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NUM_PORTS]) begin
                grant_onehot = {NUM_PORTS{1'b0}};
                grant_onehot[(int'(ptr) + k) % NUM_PORTS] = 1'b1;
                grant_idx = PORT_W'((int'(ptr) + k) % NUM_PORTS);
            end else begin
                grant_idx = grant_idx;
            end
        end
    end

endmodule

// File: rtl/hcp_rx_port_arbiter.sv
// Packet-level round-robin arbiter sharing one HCP receive path among several buffered sources,
// with inter-packet gap, grant watchdog and runaway-length cutoff.
module hcp_rx_port_arbiter
    import hcp_rx_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS     = 4,
    parameter int MAX_PKT_LEN   = 2047,
    parameter int GRANT_TIMEOUT = 64,
    parameter int IFG_CYCLES    = 2
) (
    input  logic                        clk_sys,
    input  logic                        reset_n,
    input  logic                        i_arb_en,
    input  logic [NUM_PORTS-1:0]        iv_pkt_req,
    output logic [NUM_PORTS-1:0]        ov_grant,
    input  logic [NUM_PORTS*DATA_W-1:0] iv_data,
    input  logic [NUM_PORTS-1:0]        iv_data_wr,
    input  logic [NUM_PORTS*TS_W-1:0]   iv_rec_ts,
    output logic [DATA_W-1:0]           ov_data,
    output logic                        o_data_wr,
    output logic [TS_W-1:0]             ov_rec_ts,
    output logic                        o_pkt_done_pulse,
    output logic                        o_timeout_pulse,
    output logic                        o_discard_pulse,
    output logic [1:0]                  ov_arb_state,
    output logic [PORT_W-1:0]           ov_cur_port
);

    localparam logic [10:0] MAX_LEN_C  = 11'(MAX_PKT_LEN);
    localparam logic [15:0] WD_LAST_C  = 16'(GRANT_TIMEOUT - 1);
    localparam logic [7:0]  GAP_LAST_C = (IFG_CYCLES == 0) ? 8'd0 : 8'(IFG_CYCLES - 1);

    arb_state_e           state_r;
    logic [NUM_PORTS-1:0] grant_r;
    logic [PORT_W-1:0]    ptr_r;
    logic [PORT_W-1:0]    cur_port_r;
    logic [DATA_W-1:0]    data_r;
    logic                 data_wr_r;
    logic [TS_W-1:0]      rec_ts_r;
    logic                 done_r;
    logic                 timeout_r;
    logic                 discard_r;
    logic [10:0]          beat_cnt_r;
    logic [15:0]          wd_cnt_r;
    logic [7:0]           gap_cnt_r;

    logic [NUM_PORTS-1:0] pick_onehot_s;
    logic [PORT_W-1:0]    pick_idx_s;
    logic                 pick_valid_s;
    logic [DATA_W-1:0]    sel_data_s;
    logic [TS_W-1:0]      sel_ts_s;
    logic                 sel_wr_s;
    logic                 stray_wr_s;
    logic                 bad_first_s;
    logic [10:0]          beat_next_s;

    hcp_rx_port_arbiter_rr_pick #(.NUM_PORTS(NUM_PORTS)) u_rr_pick (
        .req          (iv_pkt_req),
        .ptr          (ptr_r),
        .grant_onehot (pick_onehot_s),
        .grant_idx    (pick_idx_s),
        .valid        (pick_valid_s)
    );

    // AND-OR mux of the currently granted port's beat, valid and timestamp.
    always_comb begin
        sel_data_s = {DATA_W{1'b0}};
        sel_ts_s   = {TS_W{1'b0}};
        sel_wr_s   = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            sel_data_s = sel_data_s | (iv_data[i*DATA_W +: DATA_W] & {DATA_W{cur_port_r == PORT_W'(i)}});
            sel_ts_s   = sel_ts_s | (iv_rec_ts[i*TS_W +: TS_W] & {TS_W{cur_port_r == PORT_W'(i)}});
            sel_wr_s   = sel_wr_s | (iv_data_wr[i] & grant_r[i]);
        end
    end

    // Any beat from an ungranted port, or a granted beat that is not a valid packet start, is dropped.
    always_comb begin
        stray_wr_s  = |(iv_data_wr & ~grant_r);
        bad_first_s = (state_r == ST_GRANT) && sel_wr_s && !sel_data_s[8];
        beat_next_s = beat_cnt_r + 11'd1;
    end

    // Arbitration FSM with registered output path and watchdog counters.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            grant_r    <= {NUM_PORTS{1'b0}};
            ptr_r      <= {PORT_W{1'b0}};
            cur_port_r <= {PORT_W{1'b0}};
            data_r     <= {DATA_W{1'b0}};
            data_wr_r  <= 1'b0;
            rec_ts_r   <= {TS_W{1'b0}};
            done_r     <= 1'b0;
            timeout_r  <= 1'b0;
            discard_r  <= 1'b0;
            beat_cnt_r <= 11'd0;
            wd_cnt_r   <= 16'd0;
            gap_cnt_r  <= 8'd0;
        end else begin
            data_r    <= {DATA_W{1'b0}};
            data_wr_r <= 1'b0;
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
            discard_r <= stray_wr_s | bad_first_s;
            case (state_r)
                ST_IDLE: begin
                    wd_cnt_r   <= 16'd0;
                    beat_cnt_r <= 11'd0;
                    gap_cnt_r  <= 8'd0;
                    if (i_arb_en && pick_valid_s) begin
                        grant_r    <= pick_onehot_s;
                        cur_port_r <= pick_idx_s;
                        ptr_r      <= next_port(pick_idx_s, NUM_PORTS);
                        state_r    <= ST_GRANT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (sel_wr_s && sel_data_s[8]) begin
                        data_r     <= sel_data_s;
                        data_wr_r  <= 1'b1;
                        rec_ts_r   <= sel_ts_s;
                        beat_cnt_r <= 11'd1;
                        state_r    <= ST_XFER;
                    end else if (wd_cnt_r >= WD_LAST_C) begin
                        timeout_r <= 1'b1;
                        grant_r   <= {NUM_PORTS{1'b0}};
                        state_r   <= ST_GAP;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + 16'd1;
                    end
                end
                ST_XFER: begin
                    if (sel_wr_s) begin
                        beat_cnt_r <= beat_next_s;
                        data_wr_r  <= 1'b1;
                        if (sel_data_s[8]) begin
                            data_r  <= sel_data_s;
                            done_r  <= 1'b1;
                            grant_r <= {NUM_PORTS{1'b0}};
                            state_r <= ST_GAP;
                        end else if (beat_next_s >= MAX_LEN_C) begin
                            // Runaway packet: mark the cut-off beat as last so the parser closes it.
                            data_r    <= sel_data_s | 9'h100;
                            timeout_r <= 1'b1;
                            grant_r   <= {NUM_PORTS{1'b0}};
                            state_r   <= ST_GAP;
                        end else begin
                            data_r <= sel_data_s;
                        end
                    end else begin
                        state_r <= ST_XFER;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r >= GAP_LAST_C) begin
                        gap_cnt_r <= 8'd0;
                        state_r   <= ST_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 8'd1;
                    end
                end
                default: begin
                    grant_r <= {NUM_PORTS{1'b0}};
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign ov_grant         = grant_r;
    assign ov_data          = data_r;
    assign o_data_wr        = data_wr_r;
    assign ov_rec_ts        = rec_ts_r;
    assign o_pkt_done_pulse = done_r;
    assign o_timeout_pulse  = timeout_r;
    assign o_discard_pulse  = discard_r;
    assign ov_arb_state     = state_r;
    assign ov_cur_port      = cur_port_r;

endmodule
